multi_bank_buffer: RTL and testbench



---
 rtl/buffer_pkg.sv | 15 +
 rtl/buffer_ram.sv | 29 ++
 rtl/multi_bank_buffer.sv | 99 +++++++++
 tb/tb_multi_bank_buffer.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/buffer_pkg.sv
// buffer_pkg: default parameters and derived widths shared by the multi-bank buffer.
package buffer_pkg;
    localparam int DEFAULT_DATA_WIDTH    = 10;
    localparam int DEFAULT_BANK_DEPTH    = 8192;
    localparam int DEFAULT_BANK_COUNT    = 4;
    localparam int DEFAULT_OVERFLOW_HOLD = 1000;
    localparam int ADDR_W  = $clog2(DEFAULT_BANK_DEPTH);
    localparam int BANK_W  = $clog2(DEFAULT_BANK_COUNT);
    localparam int COUNT_W = BANK_W + 1;

    // A count of n banks must also represent n itself, hence the extra bit.
    function automatic int count_width(input int n);
        return $clog2(n) + 1;
    endfunction
endpackage

// File: rtl/buffer_ram.sv
// buffer_ram: simple dual-port RAM with one-cycle registered, enable-held read output.
module buffer_ram #(
    parameter int DATA_WIDTH = buffer_pkg::DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = buffer_pkg::ADDR_W + buffer_pkg::BANK_W
) (
    input  logic                  clock,
    input  logic                  nReset,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic                  re_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);
    logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    always_ff @(posedge clock) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    // Only the output register is reset; the array keeps its contents.
    always_ff @(posedge clock) begin
        if (!nReset) rdata_q <= '0;
        else if (re_i) rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/multi_bank_buffer.sv
// multi_bank_buffer: bank-granular ping-pong style buffer; whole banks become readable on fill.
// Define BUFFER_OVERFLOW_COUNT_EN to add the saturating overflowCount output.
module multi_bank_buffer
    import buffer_pkg::*;
#(
    parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH,
    parameter int BANK_DEPTH    = DEFAULT_BANK_DEPTH,
    parameter int BANK_COUNT    = DEFAULT_BANK_COUNT,
    parameter int OVERFLOW_HOLD = DEFAULT_OVERFLOW_HOLD
) (
    input  logic                          clock,
    input  logic                          nReset,
    input  logic                          isWriting,
    input  logic [DATA_WIDTH-1:0]         dataIn,
    input  logic                          isReading,
    output logic [DATA_WIDTH-1:0]         dataOut,
    output logic                          dataAvailable,
    output logic                          bufferOverflow,
    output logic [$clog2(BANK_COUNT):0]   banksFull
`ifdef BUFFER_OVERFLOW_COUNT_EN
    ,output logic [15:0]                  overflowCount
`endif
);
    localparam int AW = $clog2(BANK_DEPTH);
    localparam int BW = $clog2(BANK_COUNT);
    localparam int CW = count_width(BANK_COUNT);
    localparam int HW = $clog2(OVERFLOW_HOLD + 1);

    logic [AW-1:0] waddr_q, waddr_d, raddr_q, raddr_d;
    logic [BW-1:0] wbank_q, wbank_d, rbank_q, rbank_d;
    logic [CW-1:0] full_q, full_d;
    logic [HW-1:0] hold_q, hold_d;
    logic          wr_en, rd_en, drop, bank_commit, bank_release;

    assign wr_en        = isWriting && (full_q != CW'(BANK_COUNT));
    assign drop         = isWriting && (full_q == CW'(BANK_COUNT));
    assign rd_en        = isReading && (full_q != '0);
    assign bank_commit  = wr_en && (&waddr_q);
    assign bank_release = rd_en && (&raddr_q);

    // Power-of-two depth and count let pointers wrap by plain overflow.
    always_comb begin
        waddr_d = wr_en ? waddr_q + 1'b1 : waddr_q;
        raddr_d = rd_en ? raddr_q + 1'b1 : raddr_q;
        wbank_d = bank_commit ? wbank_q + 1'b1 : wbank_q;
        rbank_d = bank_release ? rbank_q + 1'b1 : rbank_q;
        full_d  = full_q + CW'(bank_commit) - CW'(bank_release);
        hold_d  = drop ? HW'(OVERFLOW_HOLD) : (hold_q != '0 ? hold_q - 1'b1 : hold_q);
    end

    always_ff @(posedge clock) begin
        if (!nReset) begin
            waddr_q <= '0;
            raddr_q <= '0;
            wbank_q <= '0;
            rbank_q <= '0;
            full_q  <= '0;
            hold_q  <= '0;
        end else begin
            waddr_q <= waddr_d;
            raddr_q <= raddr_d;
            wbank_q <= wbank_d;
            rbank_q <= rbank_d;
            full_q  <= full_d;
            hold_q  <= hold_d;
        end
    end

`ifdef BUFFER_OVERFLOW_COUNT_EN
    logic [15:0] ocnt_q, ocnt_d;

    assign ocnt_d = (drop && ocnt_q != 16'hFFFF) ? ocnt_q + 16'd1 : ocnt_q;

    always_ff @(posedge clock) begin
        if (!nReset) ocnt_q <= '0;
        else ocnt_q <= ocnt_d;
    end

    assign overflowCount = ocnt_q;
`endif

    buffer_ram #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(BW + AW)
    ) u_ram (
        .clock  (clock),
        .nReset (nReset),
        .we_i   (wr_en),
        .waddr_i({wbank_q, waddr_q}),
        .wdata_i(dataIn),
        .re_i   (rd_en),
        .raddr_i({rbank_q, raddr_q}),
        .rdata_o(dataOut)
    );

    assign dataAvailable  = full_q != '0;
    assign bufferOverflow = hold_q != '0;
    assign banksFull      = full_q;
endmodule

// File: tb/tb_multi_bank_buffer.sv
// tb_multi_bank_buffer: directed and random stimulus checked against a queue-based model.
module tb_multi_bank_buffer;
    localparam int DW = 10;
    localparam int DEPTH = 16;
    localparam int COUNT = 4;
    localparam int HOLD = 8;

    logic          clock = 1'b0;
    logic          nReset = 1'b0;
    logic          isWriting = 1'b0;
    logic [DW-1:0] dataIn = '0;
    logic          isReading = 1'b0;
    logic [DW-1:0] dataOut;
    logic          dataAvailable;
    logic          bufferOverflow;
    logic [2:0]    banksFull;
`ifdef BUFFER_OVERFLOW_COUNT_EN
    logic [15:0]   overflowCount;
`endif

    multi_bank_buffer #(
        .DATA_WIDTH(DW),
        .BANK_DEPTH(DEPTH),
        .BANK_COUNT(COUNT),
        .OVERFLOW_HOLD(HOLD)
    ) dut (
        .clock         (clock),
        .nReset        (nReset),
        .isWriting     (isWriting),
        .dataIn        (dataIn),
        .isReading     (isReading),
        .dataOut       (dataOut),
        .dataAvailable (dataAvailable),
        .bufferOverflow(bufferOverflow),
        .banksFull     (banksFull)
`ifdef BUFFER_OVERFLOW_COUNT_EN
        ,.overflowCount(overflowCount)
`endif
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad = 0;
    int committed[$];
    int partial[$];
    int exp_dout = 0;
    int since = 0;
    bit had_drop = 1'b0;
    int ocnt = 0;

    function automatic int model_full();
        return (committed.size() + DEPTH - 1) / DEPTH;
    endfunction

    task automatic check(input string tag);
        int f;
        f = model_full();
        total++;
        assert (dataOut === DW'(exp_dout)) else begin
            bad++;
            $error("FAIL %s dataOut: got %0d want %0d", tag, dataOut, exp_dout);
        end
        total++;
        assert (banksFull === 3'(f)) else begin
            bad++;
            $error("FAIL %s banksFull: got %0d want %0d", tag, banksFull, f);
        end
        total++;
        assert (dataAvailable === (f != 0)) else begin
            bad++;
            $error("FAIL %s dataAvailable: got %0d want %0d", tag, dataAvailable, f != 0);
        end
        total++;
        assert (bufferOverflow === (had_drop && since < HOLD)) else begin
            bad++;
            $error("FAIL %s bufferOverflow: got %0d want %0d", tag, bufferOverflow, had_drop && since < HOLD);
        end
`ifdef BUFFER_OVERFLOW_COUNT_EN
        total++;
        assert (overflowCount === 16'(ocnt)) else begin
            bad++;
            $error("FAIL %s overflowCount: got %0d want %0d", tag, overflowCount, ocnt);
        end
`endif
    endtask

    // Model decisions use the bank count as it stands before the edge.
    task automatic step(input bit w, input int d, input bit r, input string tag);
        int f;
        f = model_full();
        isWriting = w;
        dataIn = DW'(d);
        isReading = r;
        if (r && f > 0) exp_dout = committed.pop_front();
        if (w && f == COUNT) begin
            had_drop = 1'b1;
            since = 0;
            if (ocnt < 65535) ocnt++;
        end else begin
            since++;
            if (w) begin
                partial.push_back(d & ((1 << DW) - 1));
                if (partial.size() == DEPTH) begin
                    foreach (partial[i]) committed.push_back(partial[i]);
                    partial.delete();
                end
            end
        end
        @(posedge clock);
        #1;
        check(tag);
    endtask

    task automatic do_reset(input string tag);
        nReset = 1'b0;
        isWriting = 1'b0;
        isReading = 1'b0;
        @(posedge clock);
        #1;
        nReset = 1'b1;
        committed.delete();
        partial.delete();
        exp_dout = 0;
        had_drop = 1'b0;
        since = 0;
        ocnt = 0;
        check(tag);
    endtask

    initial begin
        do_reset("reset");
        for (int i = 0; i < DEPTH; i++) step(1, i, 0, "fill_one");
        for (int i = 0; i < DEPTH; i++) step(0, 0, 1, "read_one");
        step(0, 0, 0, "after_read");

        do_reset("reset2");
        for (int i = 0; i < DEPTH - 1; i++) step(1, 100 + i, 0, "partial");
        for (int i = 0; i < 4; i++) step(0, 0, 1, "partial_read");
        step(1, 115, 0, "partial_commit");
        for (int i = 0; i < DEPTH; i++) step(0, 0, 1, "partial_drain");

        do_reset("reset3");
        for (int i = 0; i < DEPTH * COUNT; i++) step(1, 200 + i, 0, "fill_all");
        for (int i = 0; i < 3; i++) step(1, 900 + i, 0, "drop");
        for (int i = 0; i < HOLD + 3; i++) step(0, 0, 0, "hold");
        for (int i = 0; i < DEPTH * COUNT; i++) step(0, 0, 1, "drain_all");

        do_reset("reset4");
        for (int i = 0; i < 2 * DEPTH - 1; i++) step(1, 300 + i, 0, "sim_fill");
        for (int i = 0; i < DEPTH - 1; i++) step(0, 0, 1, "sim_read");
        step(1, 347, 1, "sim_commit_release");
        for (int i = 0; i < 2 * DEPTH; i++) step(0, 0, 1, "sim_drain");

        do_reset("reset5");
        for (int i = 0; i < 40; i++) step(1, 400 + i, 0, "pre_reset");
        do_reset("mid_reset");
        for (int i = 0; i < DEPTH; i++) step(1, 500 + i, 0, "post_fill");
        for (int i = 0; i < DEPTH; i++) step(0, 0, 1, "post_read");

        for (int i = 0; i < 1500; i++) begin
            int rp;
            rp = (i < 700) ? 30 : 70;
            if (i == 1000) do_reset("rand_reset");
            step($urandom_range(0, 99) < 60, int'($urandom_range(0, 1023)),
                 $urandom_range(0, 99) < rp, "random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
